// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared RV32I pipeline constants and types
package rv_pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic {ST_RUN, ST_SQUASH} sq_state_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            exc;
  } mem_pkt_t;

  function automatic logic [XLEN-1:0] link_addr(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - EX input, MEM output and redirect bundle of the EX/MEM stage
interface ex_mem_stage_if;
  import rv_pipe_pkg::*;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] alu_result;
  logic            zero_flag;
  logic            less_than_flag;
  logic [XLEN-1:0] ex_rs2_data;
  logic [2:0]      ex_funct3;
  logic            ex_is_branch;
  logic            ex_is_jal;
  logic            ex_is_jalr;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            mem_ready;
  logic            mem_valid;
  logic [XLEN-1:0] mem_result;
  logic [XLEN-1:0] mem_store_data;
  logic [2:0]      mem_funct3;
  logic [4:0]      mem_rd;
  logic            mem_reg_write;
  logic            mem_mem_read;
  logic            mem_mem_write;
  logic            mem_exc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output ex_valid, ex_pc, ex_imm, alu_result, zero_flag, less_than_flag, ex_rs2_data,
           ex_funct3, ex_is_branch, ex_is_jal, ex_is_jalr, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, mem_ready,
    input  ex_ready, mem_valid, mem_result, mem_store_data, mem_funct3, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, mem_exc, redirect_valid, redirect_pc
  );

  modport slave (
    input  ex_valid, ex_pc, ex_imm, alu_result, zero_flag, less_than_flag, ex_rs2_data,
           ex_funct3, ex_is_branch, ex_is_jal, ex_is_jalr, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, mem_ready,
    output ex_ready, mem_valid, mem_result, mem_store_data, mem_funct3, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, mem_exc, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - conditional branch outcome from funct3 and ALU flags
module branch_cond
  import rv_pipe_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      FUNCT3_BEQ:  taken = zero;
      FUNCT3_BNE:  taken = !zero;
      FUNCT3_BLT:  taken = lt;
      FUNCT3_BGE:  taken = !lt;
      FUNCT3_BLTU: taken = lt;
      FUNCT3_BGEU: taken = !lt;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM register with branch/jump resolution, redirect pulse and wrong-path squash
module ex_mem_stage #(
  parameter int unsigned XLEN       = 32,
  parameter logic [31:0] RESET_PC_Z = 32'h0
) (
  input logic          clk,
  input logic          rst,
  ex_mem_stage_if.slave bus
);
  import rv_pipe_pkg::*;

  sq_state_e       state_q, state_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            mem_valid_q, mem_valid_d;
  mem_pkt_t        pkt_q, pkt_d;

  logic            ex_ready;
  logic            accept;
  logic            squash;
  logic            cond_taken;
  logic            take;
  logic            misaligned;
  logic            redirect_issue;
  logic            no_writes;
  logic [XLEN-1:0] target;

  branch_cond u_branch_cond (
    .funct3 (bus.ex_funct3),
    .zero   (bus.zero_flag),
    .lt     (bus.less_than_flag),
    .taken  (cond_taken)
  );

  always_comb begin
    ex_ready       = !mem_valid_q || bus.mem_ready;
    accept         = bus.ex_valid && ex_ready;
    squash         = (state_q == ST_SQUASH);
    target         = bus.ex_is_jalr ? (bus.alu_result & ~32'h1) : (bus.ex_pc + bus.ex_imm);
    take           = accept && !squash &&
                     (bus.ex_is_jal || bus.ex_is_jalr || (bus.ex_is_branch && cond_taken));
    misaligned     = target[1];
    redirect_issue = take && !misaligned;
    // Branches never write; faulting and wrong-path instructions must not either.
    no_writes      = (take && misaligned) || squash || bus.ex_is_branch;

    // The squash window is exactly the redirect pulse, so SQUASH always falls back to RUN.
    state_d = ST_RUN;
    case (state_q)
      ST_RUN:    state_d = redirect_issue ? ST_SQUASH : ST_RUN;
      ST_SQUASH: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    redirect_pc_d = redirect_issue ? target : '0;

    mem_valid_d = mem_valid_q;
    pkt_d       = pkt_q;
    if (accept) begin
      mem_valid_d      = !squash;
      pkt_d.result     = (bus.ex_is_jal || bus.ex_is_jalr) ? link_addr(bus.ex_pc) : bus.alu_result;
      pkt_d.store_data = bus.ex_rs2_data;
      pkt_d.funct3     = bus.ex_funct3;
      pkt_d.rd         = bus.ex_rd;
      pkt_d.reg_write  = bus.ex_reg_write && !no_writes;
      pkt_d.mem_read   = bus.ex_mem_read && !no_writes;
      pkt_d.mem_write  = bus.ex_mem_write && !no_writes;
      pkt_d.exc        = take && misaligned;
    end else if (bus.mem_ready) begin
      mem_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      redirect_pc_q <= '0;
      mem_valid_q   <= 1'b0;
      pkt_q         <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      mem_valid_q   <= mem_valid_d;
      pkt_q         <= pkt_d;
    end
  end

  assign bus.ex_ready       = ex_ready;
  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_result     = pkt_q.result;
  assign bus.mem_store_data = pkt_q.store_data;
  assign bus.mem_funct3     = pkt_q.funct3;
  assign bus.mem_rd         = pkt_q.rd;
  assign bus.mem_reg_write  = pkt_q.reg_write;
  assign bus.mem_mem_read   = pkt_q.mem_read;
  assign bus.mem_mem_write  = pkt_q.mem_write;
  assign bus.mem_exc        = pkt_q.exc;
  assign bus.redirect_valid = (state_q == ST_SQUASH);
  assign bus.redirect_pc    = (state_q == ST_SQUASH) ? redirect_pc_q : RESET_PC_Z;

endmodule
